// File: rtl/decoder_pkg.sv
// Types and sizes shared between the fetch byte buffer and the x86-64 decoder.
package decoder_pkg;

    localparam int unsigned MAX_INST_BYTES = 15;
    localparam int unsigned FETCH_BYTES    = 8;

    // Big-endian instruction window: byte 0 occupies bits [0:7].
    typedef logic [0:MAX_INST_BYTES*8-1] inst_window_t;

endpackage : decoder_pkg

// File: rtl/fetch_window_mux.sv
// Rotates the circular byte store so the oldest MAX_INST_BYTES bytes appear in order.
// Lanes past the valid byte count read as zero.
module fetch_window_mux
    import decoder_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 32,
    parameter int unsigned AW          = $clog2(DEPTH_BYTES)
) (
    input  logic [7:0]    storage_i [DEPTH_BYTES],
    input  logic [AW-1:0] head_i,
    input  logic [AW:0]   count_i,
    output inst_window_t  window_o,
    output logic [4:0]    window_bytes_o
);

    localparam int unsigned CW = AW + 1;

    logic [4:0] nbytes;

    always_comb begin
        nbytes   = (count_i > CW'(MAX_INST_BYTES)) ? 5'(MAX_INST_BYTES) : 5'(count_i);
        window_o = '0;
        for (int i = 0; i < int'(MAX_INST_BYTES); i++) begin
            if (5'(i) < nbytes) begin
                window_o[i*8 +: 8] = storage_i[AW'(head_i + AW'(i))];
            end
        end
    end

    assign window_bytes_o = nbytes;

endmodule : fetch_window_mux

// File: rtl/fetch_byte_buffer.sv
// Circular instruction byte queue feeding the decoder a 15-byte window.
// Optional counters enabled by defining FETCH_BYTE_BUFFER_STATS_EN.
module fetch_byte_buffer
    import decoder_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 32,
    parameter int unsigned FILL_BYTES  = FETCH_BYTES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fill_valid,
    output logic                    fill_ready,
    input  logic [FILL_BYTES*8-1:0] fill_data,
    input  logic [2:0]              fill_skip,
    input  logic                    flush,
    output inst_window_t            window,
    output logic [4:0]              window_bytes,
    output logic                    window_full,
    input  logic                    consume_en,
    input  logic [3:0]              consume_bytes,
    output logic                    consume_err
`ifdef FETCH_BYTE_BUFFER_STATS_EN
    ,
    output logic [31:0]             stat_bytes_consumed,
    output logic [31:0]             stat_starve_cycles
`endif
);

    localparam int unsigned AW = $clog2(DEPTH_BYTES);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    storage_q [DEPTH_BYTES];
    logic [AW-1:0] head_q, head_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    logic [AW-1:0] tail;
    logic [CW-1:0] fill_add;
    logic          fill_fire;
    logic          consume_ok;

    assign tail       = head_q + count_q[AW-1:0];
    assign fill_ready = (CW'(DEPTH_BYTES) - count_q) >= CW'(FILL_BYTES);
    assign fill_fire  = fill_valid && fill_ready && !flush;
    assign fill_add   = CW'(FILL_BYTES) - CW'(fill_skip);
    assign consume_ok = consume_en && !flush && (consume_bytes != 4'd0)
                        && (CW'(consume_bytes) <= count_q);

    // Flush overrides everything; otherwise fill and consume combine in one step.
    always_comb begin
        head_d  = head_q;
        count_d = count_q;
        err_d   = err_q;
        if (flush) begin
            head_d  = '0;
            count_d = '0;
        end else begin
            if (consume_ok) begin
                head_d  = head_q + AW'(consume_bytes);
                count_d = count_q - CW'(consume_bytes);
            end else if (consume_en) begin
                err_d = 1'b1;
            end
            if (fill_fire) begin
                count_d = count_d + fill_add;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Skipped leading bytes are dropped, so byte fill_skip lands at the tail.
    always_ff @(posedge clk) begin
        if (reset && fill_fire) begin
            for (int k = 0; k < int'(FILL_BYTES); k++) begin
                if (k >= int'(fill_skip)) begin
                    storage_q[AW'(tail + AW'(k) - AW'(fill_skip))] <= fill_data[k*8 +: 8];
                end
            end
        end
    end

    fetch_window_mux #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .AW          (AW)
    ) u_window_mux (
        .storage_i      (storage_q),
        .head_i         (head_q),
        .count_i        (count_q),
        .window_o       (window),
        .window_bytes_o (window_bytes)
    );

    assign window_full = (window_bytes == 5'(MAX_INST_BYTES));
    assign consume_err = err_q;

`ifdef FETCH_BYTE_BUFFER_STATS_EN
    logic [31:0] stat_bytes_q, stat_starve_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_bytes_q  <= '0;
            stat_starve_q <= '0;
        end else begin
            if (consume_ok) begin
                stat_bytes_q <= stat_bytes_q + 32'(consume_bytes);
            end
            if (!window_full && !flush) begin
                stat_starve_q <= stat_starve_q + 32'd1;
            end
        end
    end

    assign stat_bytes_consumed = stat_bytes_q;
    assign stat_starve_cycles  = stat_starve_q;
`endif

endmodule : fetch_byte_buffer

// File: doc/fetch_byte_buffer.md
Name: fetch_byte_buffer

Overview:
- Instruction byte queue that sits directly upstream of the x86-64 decoder.
- Accepts 8-byte fetch lines from the bus-side fetch logic and stores them in a circular byte buffer.
- Presents the oldest 15 bytes as a big-endian window (byte 0 at bits [0:7]) to the decoder.
- Retires the number of bytes the decoder reports consumed each cycle.

Parameters:
- DEPTH_BYTES, 32: buffer capacity in bytes; power of two, at least 16 and at least 2*FILL_BYTES.
- FILL_BYTES, 8: bytes per fill beat; fixed to the bus fetch width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- fill_valid  input  1  a fill beat is offered.
- fill_ready  output  1  buffer can accept a full beat this cycle.
- fill_data  input  64  fill bytes; byte k = fill_data[8k+7:8k], so byte 0 is oldest.
- fill_skip  input  3  leading bytes of this beat to discard; nonzero only on the first beat after flush.
- flush  input  1  discard all contents (branch redirect).
- window  output  120  bits [0:119]; byte i = window[i*8 +: 8], byte i is the i-th oldest.
- window_bytes  output  5  valid bytes in window, min(count,15).
- window_full  output  1  window_bytes == 15.
- consume_en  input  1  decoder retires bytes.
- consume_bytes  input  4  bytes retired, 1..15.
- consume_err  output  1  sticky; set on an illegal consume.

Behaviour:
- State:
  - storage: DEPTH_BYTES bytes.
  - head: log2(DEPTH_BYTES) bits.
  - count: log2(DEPTH_BYTES)+1 bits.
  - Tail is derived as (head+count) mod DEPTH_BYTES.
- Reset (reset==0 at posedge):
  - head=0, count=0, consume_err=0.
  - Storage contents are don't-care.
  - Outputs after reset: fill_ready=1, window_bytes=0, window_full=0.
- Fill accept:
  - fill_ready = (DEPTH_BYTES - count >= FILL_BYTES), computed from registered count only; a same-cycle consume does not raise it.
  - A beat is accepted when fill_valid && fill_ready && !flush.
  - It writes bytes fill_skip..7 at tail onward, wrapping modulo DEPTH_BYTES.
  - count increases by 8 - fill_skip.
- Consume:
  - Legal when consume_en && consume_bytes != 0 && consume_bytes <= count (registered).
  - On a legal consume: head += consume_bytes (mod DEPTH_BYTES), count -= consume_bytes.
  - On an illegal consume (consume_bytes > count, or consume_bytes == 0 with consume_en): no state change and consume_err is set.
  - consume_err is cleared only by reset; flush does not clear it.
- Simultaneous fill and consume in the same cycle: both apply, and next count = count + added - consumed.
- Flush:
  - Next head = 0, next count = 0.
  - Any fill or consume in the same cycle is ignored.
  - fill_ready is unaffected by flush in the flush cycle.
- Window:
  - Combinational from registered state; byte i = storage[(head+i) mod DEPTH_BYTES].
  - Bytes at i >= window_bytes are driven 8'h00.
- Latency:
  - A beat accepted at edge N is visible in window after edge N.
  - A consume at edge N advances the window after edge N.
  - The decoder may consume every cycle; sustained throughput is up to 8 bytes/cycle in steady state.
- Wrap-around: writes and window reads wrap at DEPTH_BYTES-1 -> 0 with no bubble.
- Full: count == DEPTH_BYTES is legal; fill_ready=0 and window stays valid.
- Empty: window_bytes=0, window all zero, and any consume is illegal.
- Reset mid-operation (including with fill_valid high): reset wins and state returns to the reset values above.

Optional Feature:
- Macro: FETCH_BYTE_BUFFER_STATS_EN.
- When defined:
  - Adds outputs stat_bytes_consumed (32) and stat_starve_cycles (32).
  - stat_bytes_consumed accumulates the bytes of every legal consume.
  - stat_starve_cycles increments each cycle where window_full==0 and flush==0.
  - Both counters zero on reset, wrap modulo 2^32, and are not cleared by flush.
- When undefined: the ports and logic are absent, and the behaviour is otherwise identical.

Decomposition:
- Shared package decoder_pkg:
  - MAX_INST_BYTES=15.
  - FETCH_BYTES=8.
  - typedef inst_window_t = logic[0:MAX_INST_BYTES*8-1], so the buffer and the decoder share the window type.
- One sub-module: fetch_window_mux.
  - Combinational rotator: storage + head + count -> window with zero fill.
  - Reused by the verification reference model.

Test Plan:
- Reset, then fill 8'h01..8'h08 (skip=0) -> next cycle window_bytes=8, window bytes 0..7 = 01..08 and bytes 8..14 = 00, fill_ready=1.
- Fill two beats (bytes 00..0F), consume 3 -> window byte0=03, window_bytes=13; consume 15 -> no change, consume_err=1.
- Fill to count=32 -> fill_ready=0; fill_valid held high is not accepted; consume 8 in the same cycle -> count=24, and fill_ready=1 only on the following cycle.
- Advance head to 28, then fill 8 bytes AA..B1 -> writes wrap to storage[28..31,0..3]; window byte0=AA, byte7=B1.
- Flush while fill_valid=1 and consume_en=1 -> count=0 and the fill is dropped; next beat with fill_skip=5 and bytes 10..17 -> window_bytes=3, window = 15,16,17.
- With FETCH_BYTE_BUFFER_STATS_EN: 4 starved cycles then consumes of 5 and 7 -> stat_starve_cycles=4, stat_bytes_consumed=12.
